// File: rtl/exe_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : CPU_Defines (package)
// Purpose  : Shared MDU opcode encoding, MDU state encoding and divider
//            iteration count for the EXE-stage multiply/divide unit.
// Contents : MDUOpType   - decoded MDU opcode carried in the EXE register
//            mdu_state_t - exe_muldiv control state
//            MDU_DIV_CYCLES - restoring-divider iterations (1 bit per cycle)
// Revision : 1.0 - initial release
// ============================================================================
package CPU_Defines;

  typedef enum logic [2:0] {
    MDU_NONE = 3'd0,
    MULT     = 3'd1,
    MULTU    = 3'd2,
    DIV      = 3'd3,
    DIVU     = 3'd4,
    MTHI     = 3'd5,
    MTLO     = 3'd6
  } MDUOpType;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_t;

  localparam int MDU_DIV_CYCLES = 32;

endpackage
`default_nettype wire

// File: rtl/exe_muldiv_div_radix2.sv
`default_nettype none
// ============================================================================
// Module   : div_radix2
// Purpose  : Iterative restoring divider on 32-bit magnitudes, one quotient
//            bit per enabled cycle.
// Ports    : clk, rst        - clock, async active-high reset
//            i_start         - load dividend/divisor, clear counter
//            i_step          - perform one restoring iteration this cycle
//            i_dividend      - dividend magnitude
//            i_divisor       - divisor magnitude
//            o_quotient      - quotient after the step performed this cycle
//            o_remainder     - remainder after the step performed this cycle
//            o_done          - this cycle's step is the final iteration
// Revision : 1.0 - initial release
// ============================================================================
module div_radix2 #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_step,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder,
  output logic        o_done
);

  logic [31:0] r_quo;      // dividend bits shift out the top, quotient bits in
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic [5:0]  r_count;

  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_sub;

  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_divisor});
  // When w_ge holds the difference is below the divisor, so 32 bits suffice.
  assign w_sub   = w_shift[31:0] - r_divisor;

  // Next-step values are exported so the final result can be committed at
  // the same edge that performs the last iteration.
  assign o_quotient  = {r_quo[30:0], w_ge};
  assign o_remainder = w_ge ? w_sub : w_shift[31:0];
  assign o_done      = i_step && (r_count == 6'(DIV_ITER - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_count   <= '0;
    end else if (i_start) begin
      r_quo     <= i_dividend;
      r_rem     <= '0;
      r_divisor <= i_divisor;
      r_count   <= '0;
    end else if (i_step) begin
      r_quo     <= o_quotient;
      r_rem     <= o_remainder;
      r_count   <= r_count + 6'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/exe_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : exe_muldiv
// Purpose  : EXE-stage multi-cycle multiply/divide unit with HI/LO registers.
//            MULT/MULTU stall 2 cycles, DIV/DIVU stall 33, MTHI/MTLO write
//            without stalling. Cancel aborts any in-flight operation.
// Ports    : clk, rst     - clock, async active-high reset
//            EXE_MDUOp    - MDU opcode of the instruction in EXE
//            EXE_BusA/B   - rs/rt operands after forwarding
//            EXE_Advance  - EXE instruction moves to MEM at this edge
//            EXE_Cancel   - EXE instruction killed, overrides everything
//            MDU_Busy     - combinational stall request
//            HI, LO       - committed HI/LO registers
// Revision : 1.0 - initial release
// ============================================================================
module exe_muldiv
  import CPU_Defines::*;
#(
  parameter int DIV_ITER = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  MDUOpType    EXE_MDUOp,
  input  logic [31:0] EXE_BusA,
  input  logic [31:0] EXE_BusB,
  input  logic        EXE_Advance,
  input  logic        EXE_Cancel,
  output logic        MDU_Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_t  r_state;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_mul_sgn;
  logic        r_q_neg;
  logic        r_r_neg;
  logic        r_div0;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic        w_div_start;
  logic        w_div_step;
  logic        w_div_last;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_lo_div;
  logic [31:0] w_hi_div;
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_prod;

  assign w_is_mul = (EXE_MDUOp == MULT) || (EXE_MDUOp == MULTU);
  assign w_is_div = (EXE_MDUOp == DIV)  || (EXE_MDUOp == DIVU);

  assign w_a_neg = (EXE_MDUOp == DIV) && EXE_BusA[31];
  assign w_b_neg = (EXE_MDUOp == DIV) && EXE_BusB[31];
  assign w_abs_a = w_a_neg ? (32'd0 - EXE_BusA) : EXE_BusA;
  assign w_abs_b = w_b_neg ? (32'd0 - EXE_BusB) : EXE_BusB;

  assign w_div_start = (r_state == S_IDLE) && w_is_div && !EXE_Cancel;
  assign w_div_step  = (r_state == S_DIV) && !EXE_Cancel;

  div_radix2 #(
    .DIV_ITER (DIV_ITER)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_div_start),
    .i_step      (w_div_step),
    .i_dividend  (w_abs_a),
    .i_divisor   (w_abs_b),
    .o_quotient  (w_quo),
    .o_remainder (w_rem),
    .o_done      (w_div_last)
  );

  // With a zero divisor the restoring loop leaves |A| as remainder, so the
  // sign-corrected remainder is already raw A; only LO needs forcing.
  // 0x8000_0000 / -1 needs no special case: |A| / 1 = 0x8000_0000, signs agree.
  assign w_lo_div = r_div0  ? 32'hFFFF_FFFF : (r_q_neg ? (32'd0 - w_quo) : w_quo);
  assign w_hi_div = r_r_neg ? (32'd0 - w_rem) : w_rem;

  // Low 64 bits of a 64x64 product of the extended operands equal the
  // 33x33 signed product, for both signed and unsigned multiplies.
  assign w_a64  = {{32{r_mul_sgn & r_a[31]}}, r_a};
  assign w_b64  = {{32{r_mul_sgn & r_b[31]}}, r_b};
  assign w_prod = w_a64 * w_b64;

  // Reset also masks the stall so the pipeline sees Busy=0 immediately.
  assign MDU_Busy = !rst && !EXE_Cancel &&
                    (((r_state == S_IDLE) && (w_is_mul || w_is_div)) ||
                     (r_state == S_MUL) || (r_state == S_DIV));

  assign HI = r_hi;
  assign LO = r_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_hi      <= '0;
      r_lo      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_mul_sgn <= 1'b0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_div0    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!EXE_Cancel) begin
            if (w_is_mul) begin
              r_a       <= EXE_BusA;
              r_b       <= EXE_BusB;
              r_mul_sgn <= (EXE_MDUOp == MULT);
              r_state   <= S_MUL;
            end else if (w_is_div) begin
              r_q_neg <= w_a_neg ^ w_b_neg;
              r_r_neg <= w_a_neg;
              r_div0  <= (EXE_BusB == 32'd0);
              r_state <= S_DIV;
            end else if (EXE_Advance && (EXE_MDUOp == MTHI)) begin
              r_hi <= EXE_BusA;
            end else if (EXE_Advance && (EXE_MDUOp == MTLO)) begin
              r_lo <= EXE_BusA;
            end
          end
        end
        S_MUL: begin
          if (EXE_Cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
            r_state <= S_DONE;
          end
        end
        S_DIV: begin
          if (EXE_Cancel) begin
            r_state <= S_IDLE;
          end else if (w_div_last) begin
            r_hi    <= w_hi_div;
            r_lo    <= w_lo_div;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Holding here until the instruction leaves EXE prevents a restart
          // on the same, still-present opcode.
          if (EXE_Cancel || EXE_Advance) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
